// File: rtl/bht_if.sv
// Fetch/ROB-facing signal bundle of the branch-history-table access controller.
// master = fetcher + ROB side, slave = bht_access_ctrl.
interface bht_if;
   // Handshakes: a lookup is taken in any cycle where lookup_req && lookup_ready, and its
   // result shows up on lookup_valid/lookup_taken one cycle later. An update is accepted in
   // any cycle where upd_valid && !upd_full; one offered while upd_full is high is dropped.
   logic        lookup_req;
   logic [31:0] lookup_pc;
   logic        lookup_ready;
   logic        lookup_valid;
   logic        lookup_taken;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic        upd_full;

   modport master (
      output lookup_req, lookup_pc, upd_valid, upd_pc, upd_taken,
      input  lookup_ready, lookup_valid, lookup_taken, upd_full
   );

   modport slave (
      input  lookup_req, lookup_pc, upd_valid, upd_pc, upd_taken,
      output lookup_ready, lookup_valid, lookup_taken, upd_full
   );
endinterface

// File: rtl/bht_access_ctrl.sv
// Single-port 2-bit-counter BHT controller: INIT sweep, ROB update FIFO, lookup/update
// arbitration with starvation guard. Define BHT_STAT_EN to add the statistics counters.
module bht_access_ctrl #(
   parameter int BHT_IDX_W      = 6,
   parameter int UPD_FIFO_DEPTH = 4,
   parameter int STARVE_LIMIT   = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        clear_req,
   bht_if.slave        bus,
   output logic        state_dbg_o
`ifdef BHT_STAT_EN
   ,
   output logic [31:0] stat_lookups,
   output logic [31:0] stat_updates,
   output logic [31:0] stat_mispredict
`endif
);
   localparam int N_ENT = 1 << BHT_IDX_W;
   localparam int PW    = $clog2(UPD_FIFO_DEPTH);
   localparam int CW    = PW + 1;
   localparam int SW    = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

   state_e               state_q;
   logic [BHT_IDX_W-1:0] sweep_q;
   logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]        cnt_q;
   logic [SW-1:0]        starve_q;
   logic                 lookup_valid_q, lookup_taken_q;

   logic [1:0]           tbl [N_ENT];
   logic [BHT_IDX_W-1:0] fifo_idx [UPD_FIFO_DEPTH];
   logic                 fifo_tkn [UPD_FIFO_DEPTH];

   logic                 in_run, fifo_empty, fifo_full, act;
   logic                 upd_grant, lk_grant, upd_full, enq;
   logic [BHT_IDX_W-1:0] lk_idx, up_idx, head_idx;
   logic                 head_tkn;
   logic [1:0]           head_ctr, new_ctr;
   logic                 tbl_we;
   logic [BHT_IDX_W-1:0] tbl_widx;
   logic [1:0]           tbl_wdata;
   logic                 unused_pc_bits;

   assign in_run     = (state_q == ST_RUN);
   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == CW'(UPD_FIFO_DEPTH));
   // A clear cycle grants nothing; the table is rebuilt starting next cycle.
   assign act        = rdy && in_run && !clear_req;
   assign upd_grant  = act && !fifo_empty &&
                       (!bus.lookup_req || fifo_full || (starve_q == SW'(STARVE_LIMIT)));
   assign lk_grant   = act && bus.lookup_req && !upd_grant;
   assign upd_full   = !in_run || fifo_full;
   assign enq        = rdy && !clear_req && bus.upd_valid && !upd_full;

   assign lk_idx   = bus.lookup_pc[BHT_IDX_W+1:2];
   assign up_idx   = bus.upd_pc[BHT_IDX_W+1:2];
   assign head_idx = fifo_idx[rd_ptr_q];
   assign head_tkn = fifo_tkn[rd_ptr_q];
   assign head_ctr = tbl[head_idx];

   assign unused_pc_bits = ^{bus.lookup_pc[31:BHT_IDX_W+2], bus.lookup_pc[1:0],
                             bus.upd_pc[31:BHT_IDX_W+2], bus.upd_pc[1:0]};

   always_comb begin
      new_ctr = head_ctr;
      if (head_tkn) begin
         if (head_ctr != 2'b11) new_ctr = head_ctr + 2'b01;
      end else begin
         if (head_ctr != 2'b00) new_ctr = head_ctr - 2'b01;
      end
   end

   // The single table write port is shared by the INIT sweep and the update RMW.
   always_comb begin
      tbl_we    = 1'b0;
      tbl_widx  = head_idx;
      tbl_wdata = new_ctr;
      if (rdy && !clear_req && !in_run) begin
         tbl_we    = 1'b1;
         tbl_widx  = sweep_q;
         tbl_wdata = 2'b01;
      end else if (upd_grant) begin
         tbl_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (tbl_we) tbl[tbl_widx] <= tbl_wdata;
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         fifo_idx[wr_ptr_q] <= up_idx;
         fifo_tkn[wr_ptr_q] <= bus.upd_taken;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_INIT;
         sweep_q        <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         cnt_q          <= '0;
         starve_q       <= '0;
         lookup_valid_q <= 1'b0;
         lookup_taken_q <= 1'b0;
      end else if (rdy) begin
         if (clear_req) begin
            state_q        <= ST_INIT;
            sweep_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            starve_q       <= '0;
            lookup_valid_q <= 1'b0;
         end else begin
            if (!in_run) begin
               sweep_q <= sweep_q + 1'b1;
               if (sweep_q == '1) state_q <= ST_RUN;
            end
            lookup_valid_q <= lk_grant;
            if (lk_grant) lookup_taken_q <= tbl[lk_idx][1];
            if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (upd_grant) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q    <= cnt_q + CW'(enq) - CW'(upd_grant);
            starve_q <= (upd_grant || fifo_empty) ? '0 : starve_q + 1'b1;
         end
      end
   end

`ifdef BHT_STAT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_lookups    <= '0;
         stat_updates    <= '0;
         stat_mispredict <= '0;
      end else if (rdy) begin
         if (clear_req) begin
            stat_lookups    <= '0;
            stat_updates    <= '0;
            stat_mispredict <= '0;
         end else begin
            stat_lookups    <= stat_lookups + 32'(lk_grant);
            stat_updates    <= stat_updates + 32'(upd_grant);
            stat_mispredict <= stat_mispredict + 32'(upd_grant && (head_ctr[1] != head_tkn));
         end
      end
   end
`endif

   assign bus.lookup_ready = lk_grant;
   assign bus.lookup_valid = lookup_valid_q;
   assign bus.lookup_taken = lookup_taken_q;
   assign bus.upd_full     = upd_full;
   assign state_dbg_o      = state_q;
endmodule

// File: doc/bht_access_ctrl.md
Name: bht_access_ctrl

Overview:
- Controller for the branch-prediction table: a single-port 2-bit-counter BHT shared between the instruction fetcher (lookups) and the ROB (training updates).
- Sequences table initialisation and queues ROB updates in a small FIFO.
- Arbitrates the one table slot per cycle between lookup and update.
- Sits between the fetch predictor front end and the ROB commit port.

Parameters:
- BHT_IDX_W, 6, table index width; 2^BHT_IDX_W entries.
- UPD_FIFO_DEPTH, 4, update-queue entries (power of two, >= 2).
- STARVE_LIMIT, 3, consecutive denied cycles before a queued update is forced ahead of lookups.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- rdy  input  1  global ready; low freezes all state.
- clear_req  input  1  pulse; restarts table initialisation.
- lookup_req  input  1  fetcher requests a prediction.
- lookup_pc  input  32  PC to predict.
- lookup_ready  output  1  lookup granted this cycle.
- lookup_valid  output  1  registered result valid, one cycle after grant.
- lookup_taken  output  1  predicted direction (counter MSB).
- upd_valid  input  1  ROB commits a resolved branch.
- upd_pc  input  32  branch PC.
- upd_taken  input  1  actual outcome.
- upd_full  output  1  queue cannot accept an update.

Behaviour:
- Index: pc[BHT_IDX_W+1:2]. Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Table: combinational read, synchronous write, at most one access per cycle.
- An update is a read-modify-write in one cycle: +1 if taken, saturating at 11; -1 if not taken, saturating at 00.
- States: INIT and RUN.
  - Reset (rst=0) places the block in INIT with sweep counter 0.
  - clear_req in any state also enters INIT, resets the sweep counter and flushes the FIFO.
- INIT:
  - Writes 01 to entry sweep_cnt each cycle.
  - After entry 2^BHT_IDX_W-1 is written, moves to RUN on the next cycle. INIT lasts exactly 2^BHT_IDX_W cycles.
  - lookup_ready=0 and upd_full=1; upd_valid is ignored.
- RUN arbitration, evaluated each cycle:
  - Update granted if the FIFO is non-empty and any of: no lookup_req, FIFO full, or starve_cnt==STARVE_LIMIT.
  - Otherwise lookup granted if lookup_req.
  - lookup_ready = lookup_req && !update_grant.
- Starvation counter:
  - starve_cnt increments when the FIFO is non-empty and the update is denied.
  - It clears on an update grant or when the FIFO is empty.
- Lookup result: granted in cycle N gives lookup_valid=1 and lookup_taken=counter[1] in cycle N+1. Otherwise lookup_valid=0.
- FIFO enqueue:
  - Enqueue when upd_valid && !upd_full. An update arriving while full is dropped; the ROB must stall on upd_full.
  - upd_full = (count==UPD_FIFO_DEPTH), from registered count. Full stays full even when a dequeue happens in the same cycle.
  - Simultaneous enqueue and dequeue when not full: count unchanged, order preserved. Pointers wrap modulo depth.
- rdy=0: no state, table, FIFO or counter changes.
  - lookup_ready=0.
  - lookup_valid holds its previous value.
  - upd_full reflects frozen state; incoming upd_valid is not enqueued.
- Reset values: lookup_ready 0, lookup_valid 0, lookup_taken 0, upd_full 1 (INIT), FIFO empty, starve_cnt 0.
- Reset during INIT or RUN aborts immediately; any pending lookup result is discarded.

Optional Feature:
- Macro: BHT_STAT_EN.
- Defined: adds outputs stat_lookups [31:0], stat_updates [31:0] and stat_mispredict [31:0].
  - stat_lookups counts lookup grants.
  - stat_updates counts update grants.
  - stat_mispredict counts applied updates whose pre-update counter MSB != upd_taken.
  - All counters wrap, reset to 0 on rst, and also clear on clear_req.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Release rst, rdy=1 -> lookup_ready=0 and upd_full=1 for exactly 64 cycles, then RUN. First lookup of pc 0x100 returns lookup_valid=1, lookup_taken=0 the next cycle.
- Three updates to pc 0x100 taken=1, no lookups, then lookup 0x100 -> counter 01→10→11→11; lookup_taken=1. Then one not-taken update -> 10, still taken=1.
- Continuous lookup_req while one update is queued -> update granted on the 4th cycle (starve_cnt hits 3), lookup_ready=0 that cycle, then lookup grants resume.
- Four updates enqueued back-to-back under continuous lookups -> upd_full=1. A fifth upd_valid is dropped. The update is forced next cycle; upd_full falls the cycle after the dequeue.
- rdy=0 for 5 cycles mid-RUN with lookup_req and upd_valid high -> no grants, FIFO count unchanged, table unchanged. Operation resumes identically when rdy=1.
- clear_req after training pc 0x100 to 11 -> 64-cycle INIT, FIFO empty; lookup 0x100 returns taken=0. With BHT_STAT_EN, all stats read 0.
